// File: rtl/pe_batch_sequencer.sv
// pe_batch_sequencer
// Runs one batch of operands from the PE operand buffer through the fixed-latency
// multiply/add pipeline and writes each result back into the upper half of the
// buffer. Shares the single buffer read port with SPI host reads: the host owns
// the port while the sequencer is idle.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd              host command strobe; 2'b10 START, 2'b11 ABORT
//   cmd_start/cmd_len          first operand index and operand count for START
//   host_ren/host_raddr        SPI read request and address
//   host_gnt/host_rvalid       host read accepted / host read data valid (+1 cycle)
//   buf_ren/buf_raddr          buffer read port
//   pe_en                      PE pipeline advance enable
//   res_wen/res_waddr          result write-back into slots DATA_NUM..2*DATA_NUM-1
//   busy, done, aborted        status; done/aborted are one-cycle pulses
//   err_cmd                    sticky illegal-START flag, cleared by a good START
`timescale 1ns/1ps
module pe_batch_sequencer #(
  parameter int DATA_NUM   = 16,
  parameter int ADDR_WIDTH = $clog2(2*DATA_NUM),
  parameter int PIPE_DEPTH = 3,
  parameter int CMD_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [ADDR_WIDTH-2:0] cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  host_ren,
  input  logic [ADDR_WIDTH-1:0] host_raddr,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic                  buf_ren,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  output logic                  pe_en,
  output logic                  res_wen,
  output logic [ADDR_WIDTH-1:0] res_waddr,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_cmd
);

  // One slot for the buffer read latency plus one per pipeline stage.
  localparam int SR_DEPTH = 1 + PIPE_DEPTH;

  localparam logic [CMD_WIDTH-1:0]  CMD_START = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0]  CMD_ABORT = CMD_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] NUM       = ADDR_WIDTH'(DATA_NUM);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-2:0]   start_q, start_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [SR_DEPTH-1:0]     sr_valid_q, sr_valid_d;
  logic [ADDR_WIDTH-1:0]   sr_idx_q [SR_DEPTH];
  logic [ADDR_WIDTH-1:0]   sr_idx_d [SR_DEPTH];
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    host_rvalid_q, host_rvalid_d;

  logic                    is_start, is_abort, len_ok, start_ok, abort_hit;
  logic                    last_issue, drain_empty;
  logic [ADDR_WIDTH-1:0]   rd_sum, rd_addr;

  // Command decode and batch progress conditions.
  assign is_start    = cmd_valid && (cmd == CMD_START);
  assign is_abort    = cmd_valid && (cmd == CMD_ABORT);
  assign len_ok      = (cmd_len != '0) && (cmd_len <= NUM);
  assign start_ok    = is_start && (state_q == S_IDLE) && len_ok;
  assign abort_hit   = is_abort && (state_q != S_IDLE);
  assign last_issue  = (state_q == S_ISSUE) && (idx_q == len_q - ADDR_WIDTH'(1));
  // Only the tail entry may still be valid: it leaves at this edge.
  assign drain_empty = ~|sr_valid_q[SR_DEPTH-2:0];

  // Operand address wraps inside the operand half of the buffer.
  assign rd_sum  = {1'b0, start_q} + idx_q;
  assign rd_addr = (rd_sum >= NUM) ? rd_sum - NUM : rd_sum;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ISSUE;
      S_ISSUE: if (abort_hit) state_d = S_IDLE;
               else if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (abort_hit || drain_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: batch parameters, issue index, valid tracking, flags.
  always_comb begin
    start_d       = start_q;
    len_d         = len_q;
    idx_d         = idx_q;
    err_d         = err_q;
    sr_valid_d    = {sr_valid_q[SR_DEPTH-2:0], (state_q == S_ISSUE)};
    sr_idx_d      = sr_idx_q;
    sr_idx_d[0]   = idx_q;
    for (int k = 1; k < SR_DEPTH; k++) sr_idx_d[k] = sr_idx_q[k-1];

    if (start_ok) begin
      start_d = cmd_start;
      len_d   = cmd_len;
      idx_d   = '0;
      err_d   = 1'b0;
    end else if (is_start) begin
      // Bad length, or START while a batch is running.
      err_d = 1'b1;
    end

    if (state_q == S_ISSUE) idx_d = idx_q + ADDR_WIDTH'(1);
    if (abort_hit)          sr_valid_d = '0;

    done_d        = (state_q == S_DRAIN) && drain_empty && !abort_hit;
    aborted_d     = abort_hit;
    host_rvalid_d = host_gnt;
  end

  // NOTE: the index chain of the tracking shift register is reset along with
  // its valids so that every output, including res_waddr, reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q       <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      sr_valid_q    <= '0;
      for (int k = 0; k < SR_DEPTH; k++) sr_idx_q[k] <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      start_q       <= start_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      sr_valid_q    <= sr_valid_d;
      sr_idx_q      <= sr_idx_d;
      err_q         <= err_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    pe_en     = busy;
    host_gnt  = host_ren && (state_q == S_IDLE);
    buf_ren   = 1'b0;
    buf_raddr = '0;
    unique case (state_q)
      S_IDLE: begin
        buf_ren   = host_gnt;
        buf_raddr = host_raddr;
      end
      S_ISSUE: begin
        buf_ren   = 1'b1;
        buf_raddr = rd_addr;
      end
      default: ;
    endcase
    // Results pack from slot DATA_NUM using the unwrapped issue index.
    res_wen     = sr_valid_q[SR_DEPTH-1];
    res_waddr   = res_wen ? NUM + sr_idx_q[SR_DEPTH-1] : '0;
    done        = done_q;
    aborted     = aborted_q;
    err_cmd     = err_q;
    host_rvalid = host_rvalid_q;
  end

endmodule

// File: tb/tb_pe_batch_sequencer.sv
`timescale 1ns/1ps
module tb_pe_batch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [3:0] cmd_start;
  logic [4:0] cmd_len;
  logic       host_ren;
  logic [4:0] host_raddr;
  logic       host_gnt, host_rvalid, buf_ren, pe_en, res_wen, busy, done, aborted, err_cmd;
  logic [4:0] buf_raddr, res_waddr;

  int n_checks = 0;
  int n_errors = 0;

  pe_batch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .host_ren(host_ren),
    .host_raddr(host_raddr), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .buf_ren(buf_ren), .buf_raddr(buf_raddr), .pe_en(pe_en), .res_wen(res_wen),
    .res_waddr(res_waddr), .busy(busy), .done(done), .aborted(aborted),
    .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One cycle-row: inputs driven for that cycle, outputs expected during it.
  typedef struct {
    logic       cv;
    logic [1:0] cmd;
    logic [3:0] st;
    logic [4:0] ln;
    logic       hren;
    logic [4:0] hra;
    logic       busy;
    logic       bren;
    logic [4:0] bra;
    logic       wen;
    logic [4:0] wa;
    logic       done;
    logic       ab;
    logic       err;
    logic       gnt;
    logic       rv;
  } vec_t;

  function automatic vec_t mk(int cv, int c, int st, int ln, int hren, int hra,
                              int bsy, int bren, int bra, int wen, int wa,
                              int dn, int ab, int err, int gnt, int rv);
    vec_t v;
    v.cv = 1'(cv);   v.cmd = 2'(c);    v.st = 4'(st);    v.ln = 5'(ln);
    v.hren = 1'(hren); v.hra = 5'(hra); v.busy = 1'(bsy); v.bren = 1'(bren);
    v.bra = 5'(bra); v.wen = 1'(wen);  v.wa = 5'(wa);    v.done = 1'(dn);
    v.ab = 1'(ab);   v.err = 1'(err);  v.gnt = 1'(gnt);  v.rv = 1'(rv);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cmd_valid = 1'b0; cmd = 2'd0; cmd_start = 4'd0; cmd_len = 5'd0;
    host_ren = 1'b0; host_raddr = 5'd0;
  endtask

  task automatic start_cmd(input logic [3:0] st, input logic [4:0] ln);
    cmd_valid = 1'b1; cmd = 2'b10; cmd_start = st; cmd_len = ln;
  endtask

  vec_t vecs [25];

  initial begin
    // Wrap-around batch with a same-cycle host read, illegal STARTs, a legal
    // START that clears err_cmd, back-to-back START on done, START while busy
    // and host requests stalled during a batch.
    //           cv cmd st ln hr hra  bsy br bra  we wa  dn ab er gn rv
    vecs[0]  = mk(1, 2, 14, 4, 1, 7,   0, 1, 7,   0, 0,  0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 14,  0, 0,  0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 15,  0, 0,  0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 0,   0, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0,  0, 0, 0,   1, 1, 1,   0, 0,  0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 16, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 17, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 18, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 19, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 2, 0,  0, 0, 0,   0, 0, 0,   0, 0,  1, 0, 0, 0, 0);
    vecs[10] = mk(1, 2, 0, 17, 0, 0,   0, 0, 0,   0, 0,  0, 0, 1, 0, 0);
    vecs[11] = mk(1, 2, 3,  1, 0, 0,   0, 0, 0,   0, 0,  0, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0,  0, 0, 0,   1, 1, 3,   0, 0,  0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 16, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 2, 15, 2, 0, 0,   0, 0, 0,   0, 0,  1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0,  0, 0, 0,   1, 1, 15,  0, 0,  0, 0, 0, 0, 0);
    vecs[19] = mk(1, 2, 0,  3, 1, 9,   1, 1, 0,   0, 0,  0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0,  0, 1, 9,   1, 0, 0,   0, 0,  0, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 0,  0, 1, 9,   1, 0, 0,   0, 0,  0, 0, 1, 0, 0);
    vecs[22] = mk(0, 0, 0,  0, 1, 9,   1, 0, 0,   1, 16, 0, 0, 1, 0, 0);
    vecs[23] = mk(0, 0, 0,  0, 1, 9,   1, 0, 0,   1, 17, 0, 0, 1, 0, 0);
    vecs[24] = mk(0, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0,  1, 0, 1, 0, 0);

    // Reset state.
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset pe_en", pe_en, 0);
    check("reset buf_ren", buf_ren, 0);
    check("reset res_wen", res_wen, 0);
    check("reset res_waddr", res_waddr, 0);
    check("reset done", done, 0);
    check("reset aborted", aborted, 0);
    check("reset err_cmd", err_cmd, 0);
    check("reset host_rvalid", host_rvalid, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven sequence.
    for (int r = 0; r < 25; r++) begin
      cmd_valid = vecs[r].cv;  cmd = vecs[r].cmd;  cmd_start = vecs[r].st;
      cmd_len = vecs[r].ln;    host_ren = vecs[r].hren; host_raddr = vecs[r].hra;
      @(negedge clk);
      check($sformatf("row%0d busy", r), busy, vecs[r].busy);
      check($sformatf("row%0d pe_en", r), pe_en, vecs[r].busy);
      check($sformatf("row%0d buf_ren", r), buf_ren, vecs[r].bren);
      if (vecs[r].bren) check($sformatf("row%0d buf_raddr", r), buf_raddr, vecs[r].bra);
      check($sformatf("row%0d res_wen", r), res_wen, vecs[r].wen);
      check($sformatf("row%0d res_waddr", r), res_waddr, vecs[r].wa);
      check($sformatf("row%0d done", r), done, vecs[r].done);
      check($sformatf("row%0d aborted", r), aborted, vecs[r].ab);
      check($sformatf("row%0d err_cmd", r), err_cmd, vecs[r].err);
      check($sformatf("row%0d host_gnt", r), host_gnt, vecs[r].gnt);
      check($sformatf("row%0d host_rvalid", r), host_rvalid, vecs[r].rv);
      tick();
    end
    drive_idle();
    tick();

    // Nominal full batch, host_ren held high while busy.
    start_cmd(4'd0, 5'd16);
    tick();
    drive_idle();
    for (int k = 1; k <= 22; k++) begin
      logic       e_busy, e_bren, e_wen;
      logic [4:0] e_wa;
      host_ren   = (k <= 20);
      host_raddr = 5'd5;
      e_busy = (k <= 20);
      e_bren = (k <= 16);
      e_wen  = (k >= 5) && (k <= 20);
      e_wa   = e_wen ? 5'(16 + k - 5) : 5'd0;
      @(negedge clk);
      check($sformatf("nom c%0d busy", k), busy, e_busy);
      check($sformatf("nom c%0d buf_ren", k), buf_ren, e_bren);
      if (e_bren) check($sformatf("nom c%0d buf_raddr", k), buf_raddr, k - 1);
      check($sformatf("nom c%0d res_wen", k), res_wen, e_wen);
      check($sformatf("nom c%0d res_waddr", k), res_waddr, e_wa);
      check($sformatf("nom c%0d done", k), done, (k == 21));
      check($sformatf("nom c%0d host_gnt", k), host_gnt, 0);
      tick();
    end
    drive_idle();

    // ABORT during DRAIN at cycle 6 of a 4-operand batch, then ABORT in IDLE.
    start_cmd(4'd0, 5'd4);
    tick();
    drive_idle();
    for (int k = 1; k <= 10; k++) begin
      logic e_wen;
      cmd_valid = (k == 6);
      cmd       = (k == 6) ? 2'b11 : 2'b00;
      e_wen     = (k == 5) || (k == 6);
      @(negedge clk);
      check($sformatf("abt c%0d res_wen", k), res_wen, e_wen);
      if (e_wen) check($sformatf("abt c%0d res_waddr", k), res_waddr, 16 + k - 5);
      check($sformatf("abt c%0d aborted", k), aborted, (k == 7));
      check($sformatf("abt c%0d done", k), done, 0);
      check($sformatf("abt c%0d busy", k), busy, (k <= 6));
      tick();
    end
    cmd_valid = 1'b1; cmd = 2'b11;
    tick();
    drive_idle();
    @(negedge clk);
    check("idle abort aborted", aborted, 0);
    check("idle abort busy", busy, 0);
    tick();

    // Reset mid-ISSUE: err_cmd set by a START while busy, then rst_n low at cycle 3.
    start_cmd(4'd0, 5'd4);
    tick();
    start_cmd(4'd0, 5'd2);
    tick();
    drive_idle();
    @(negedge clk);
    check("rst pre err_cmd", err_cmd, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst pre busy", busy, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst pe_en", pe_en, 0);
    check("rst buf_ren", buf_ren, 0);
    check("rst buf_raddr", buf_raddr, 0);
    check("rst res_wen", res_wen, 0);
    check("rst res_waddr", res_waddr, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst err_cmd", err_cmd, 0);
    check("rst host_gnt", host_gnt, 0);
    check("rst host_rvalid", host_rvalid, 0);
    tick();
    for (int k = 5; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("rst c%0d done", k), done, 0);
      check($sformatf("rst c%0d aborted", k), aborted, 0);
      check($sformatf("rst c%0d res_wen", k), res_wen, 0);
      check($sformatf("rst c%0d busy", k), busy, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_batch_sequencer.md
# pe_batch_sequencer

Single-clock controller that runs one batch of operands from the PE operand buffer through the multiply/add pipeline and writes the results back. It decodes host commands (START, ABORT) from the SPI write path and issues sequential buffer reads with address wrap-around. It tracks in-flight valids through the fixed-latency pipeline, generates result write-backs into the upper half of the buffer, and arbitrates the single buffer read port between itself and SPI host reads.

## Interface
- DATA_NUM, 16: operand slots; results live at DATA_NUM..2*DATA_NUM-1.
- ADDR_WIDTH, $clog2(2*DATA_NUM): buffer address width.
- PIPE_DEPTH, 3: PE pipeline latency in cycles from buffer data out to result.
- CMD_WIDTH, 2: command field width.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  one-cycle strobe: cmd/cmd_start/cmd_len are valid.
- cmd  input  CMD_WIDTH  2'b10 START, 2'b11 ABORT; other codes are ignored.
- cmd_start  input  ADDR_WIDTH-1  first operand index.
- cmd_len  input  ADDR_WIDTH  operand count, 1..DATA_NUM.
- host_ren  input  1  SPI read request.
- host_raddr  input  ADDR_WIDTH  SPI read address.
- host_gnt  output  1  host read accepted this cycle.
- host_rvalid  output  1  buffer data valid for host, one cycle after host_gnt.
- buf_ren  output  1  buffer read enable.
- buf_raddr  output  ADDR_WIDTH  buffer read address.
- pe_en  output  1  PE pipeline register advance enable.
- res_wen  output  1  result write enable.
- res_waddr  output  ADDR_WIDTH  result write address.
- busy  output  1  sequencer not IDLE.
- done  output  1  one-cycle pulse when a batch completes normally.
- aborted  output  1  one-cycle pulse when a batch is aborted.
- err_cmd  output  1  sticky flag for an illegal START; cleared by the next accepted START.

## Operation
- States:
  - IDLE: port owned by the host.
  - ISSUE: one operand read per cycle.
  - DRAIN: waiting on in-flight results.
- IDLE -> ISSUE on cmd_valid & START & 1<=cmd_len<=DATA_NUM.
  - Latch start and len; zero the issue index i.
  - Clear err_cmd.
- START with cmd_len==0 or cmd_len>DATA_NUM: ignored, err_cmd<=1.
- START while busy: ignored, err_cmd<=1; the running batch is unaffected.
- ISSUE: buf_ren=1, buf_raddr=(start+i) mod DATA_NUM, i++.
  - Go to DRAIN after the read with i==len-1.
- Valid tracking: shift register of depth 1+PIPE_DEPTH carries {valid, i}.
  - Entry at tail: res_wen=valid, res_waddr=DATA_NUM+i (unwrapped index, so results are packed from slot DATA_NUM).
- DRAIN -> IDLE when the last valid leaves the shift register; done pulses the following cycle.
- ABORT (cmd_valid & ABORT) in ISSUE or DRAIN:
  - Next cycle: state IDLE, all valids cleared, no further res_wen, aborted=1, done=0.
  - Result slots already written keep their values.
- ABORT in IDLE: ignored, no pulse.
- pe_en = (state != IDLE).
- Arbitration:
  - host_gnt = host_ren & state==IDLE.
  - In IDLE: buf_ren=host_gnt, buf_raddr=host_raddr.
  - In ISSUE/DRAIN the host is stalled. Host requests are not queued; the host must re-request.
- START and host_ren in the same IDLE cycle: both accepted, because the sequencer's first read is in the next cycle.
- rst_n low at a clock edge, including mid-batch:
  - State IDLE; counters, shift register, err_cmd and all outputs 0.
  - No done/aborted pulse is generated.

## Timing
- Buffer read latency is 1 cycle. Result for element i is written 1+PIPE_DEPTH cycles after its read.
- START sampled at edge 0:
  - ISSUE cycles 1..len; res_wen cycles 2+PIPE_DEPTH..len+1+PIPE_DEPTH.
  - DRAIN cycles len+1..len+1+PIPE_DEPTH.
  - IDLE, done=1, busy=0 at cycle len+2+PIPE_DEPTH.
- host_rvalid = host_gnt delayed 1 cycle. It is cleared by reset but not by ABORT.
- done, aborted and host_rvalid are registered. All other outputs are combinational from registered state.
- Back-to-back batches: a START is accepted on the same cycle done is high.

## Test plan
- Nominal batch (start=0, len=16, PIPE_DEPTH=3):
  - buf_raddr 0..15 in cycles 1..16.
  - res_wen cycles 5..20 with res_waddr 16..31.
  - done at cycle 21; busy high cycles 1..20.
- Wrap-around (start=14, len=4): buf_raddr 14,15,0,1; res_waddr 16..19.
- Illegal starts:
  - START len=0: err_cmd=1, busy stays 0.
  - START len=17: err_cmd=1, busy stays 0.
  - A following legal START clears err_cmd and runs.
- ABORT during DRAIN (len=4, ABORT at cycle 6):
  - res_wen seen only for res_waddr 16,17.
  - aborted=1 at cycle 7, done never asserts, busy=0 at cycle 7.
- Arbitration:
  - host_ren held high through a batch: host_gnt=0 for the whole busy period.
  - host_ren with START in the same IDLE cycle: host_gnt=1, host_rvalid next cycle, batch proceeds.
- Reset mid-ISSUE (rst_n low at cycle 3): next cycle all outputs 0 and state IDLE; no done or aborted pulse.
